// File: rtl/uart_pkg.sv
// Constants shared by the UART peripheral, the trace logger and the TX FIFO.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int unsigned fifo_level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/consumer byte streams of the UART TX FIFO.
// The master drives bytes in and takes bytes out; the FIFO is the slave.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_W flop array: synchronous write port, asynchronous read port.
// Contents are not reset; only entries between the FIFO pointers are meaningful.
module fifo_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; no reset so the array maps onto plain flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the trace logger and the UART peripheral.
// First-word fall-through, optional drop-on-full mode, fill level,
// high-water mark and saturating dropped-byte counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = UART_DATA_W,
  parameter int unsigned DEPTH        = UART_FIFO_DEPTH,
  parameter int unsigned DROP_ON_FULL = 0,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_fifo_if.slave    bus,
  output logic [AW:0]      level,
  output logic [AW:0]      high_water,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      high_water_q, high_water_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             in_ready_q, in_ready_d;

  logic             empty, full, full_nxt;
  logic             push, pop, drop;
  logic [AW:0]      level_nxt;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop in the same cycle never frees room for a push: full blocks the write.
  assign push = bus.in_valid && in_ready_q && !full;
  assign pop  = !empty && bus.out_ready;
  assign drop = (DROP_ON_FULL != 0) && bus.in_valid && full;

  // Next pointers, statistics and the registered in_ready.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    level_nxt    = wr_ptr_d - rd_ptr_d;
    high_water_d = high_water_q;
    if (level_nxt > high_water_q) high_water_d = level_nxt;
    drop_cnt_d   = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    // in_ready is a flop fed from the next pointer state, so out_ready
    // has no combinational path to in_ready.
    full_nxt     = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    in_ready_d   = (DROP_ON_FULL != 0) ? 1'b1 : !full_nxt;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      high_water_q <= '0;
      drop_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      high_water_q <= high_water_d;
      drop_cnt_q   <= drop_cnt_d;
      in_ready_q   <= in_ready_d;
    end
  end

  fifo_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (bus.out_data)
  );

  assign bus.out_valid = !empty;
  assign bus.in_ready  = in_ready_q;
  assign level         = wr_ptr_q - rd_ptr_q;
  assign high_water    = high_water_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a backpressure instance (DEPTH 16)
// and a drop-on-full instance (DEPTH 4, 5-bit drop counter).
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_if #(.DATA_W(8)) a_if ();
  uart_tx_fifo_if #(.DATA_W(8)) b_if ();

  logic [4:0]  a_level, a_hw;
  logic [15:0] a_drop;
  logic [2:0]  b_level, b_hw;
  logic [4:0]  b_drop;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .DROP_ON_FULL(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave),
    .level(a_level), .high_water(a_hw), .drop_cnt(a_drop)
  );

  uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .DROP_ON_FULL(1), .CNT_W(5)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave),
    .level(b_level), .high_water(b_hw), .drop_cnt(b_drop)
  );

  // Scoreboard for instance A
  logic [7:0] a_q[$];
  int         a_cnt = 0;
  int         a_hw_m = 0;

  // One cycle on A: drive, sample before the edge, update scoreboard.
  task automatic drive_a(input logic v, input logic [7:0] d, input logic r,
                         output logic ov, output logic [7:0] od, output logic [4:0] lv,
                         output logic ir, output logic popped, output logic [7:0] ex);
    a_if.in_valid  = v;
    a_if.in_data   = d;
    a_if.out_ready = r;
    @(negedge clk);
    ov = a_if.out_valid;
    od = a_if.out_data;
    lv = a_level;
    ir = a_if.in_ready;
    popped = (a_cnt > 0) && r;
    ex = 8'h00;
    if (popped) ex = a_q.pop_front();
    if (v && a_cnt < 16) a_q.push_back(d);
    a_cnt = a_q.size();
    if (a_cnt > a_hw_m) a_hw_m = a_cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d, input logic r, output logic [7:0] od);
    b_if.in_valid  = v;
    b_if.in_data   = d;
    b_if.out_ready = r;
    @(negedge clk);
    od = b_if.out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    a_if.in_valid = 0; a_if.in_data = '0; a_if.out_ready = 0;
    b_if.in_valid = 0; b_if.in_data = '0; b_if.out_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %0b expected 0", a_if.in_ready); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", a_if.out_valid); end
    checks++;
    if (a_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", a_level); end
    checks++;
    if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", a_if.in_ready); end
    checks++;
    if (a_drop !== 16'd0 || a_hw !== 5'd0) begin errors++; $display("FAIL reset_stats: got drop %0d hw %0d expected 0 0", a_drop, a_hw); end
  endtask

  task automatic test_single;
    logic ov, ir, pp; logic [7:0] od, ex; logic [4:0] lv;
    drive_a(1'b1, 8'h41, 1'b0, ov, od, lv, ir, pp, ex);
    drive_a(1'b0, 8'h00, 1'b0, ov, od, lv, ir, pp, ex);
    checks++;
    if (ov !== 1'b1 || od !== 8'h41) begin errors++; $display("FAIL single_latency: got valid %0b data %02h expected 1 41", ov, od); end
    checks++;
    if (lv !== 5'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", lv); end
    drive_a(1'b0, 8'h00, 1'b1, ov, od, lv, ir, pp, ex);
    checks++;
    if (!pp || od !== ex) begin errors++; $display("FAIL single_pop: got %02h expected %02h", od, ex); end
    drive_a(1'b0, 8'h00, 1'b0, ov, od, lv, ir, pp, ex);
    checks++;
    if (lv !== 5'd0 || ov !== 1'b0) begin errors++; $display("FAIL single_empty: got level %0d valid %0b expected 0 0", lv, ov); end
  endtask

  task automatic test_fill;
    logic ov, ir, pp; logic [7:0] od, ex; logic [4:0] lv;
    for (int i = 0; i < 16; i++) drive_a(1'b1, 8'(i), 1'b0, ov, od, lv, ir, pp, ex);
    drive_a(1'b1, 8'h10, 1'b0, ov, od, lv, ir, pp, ex);
    checks++;
    if (lv !== 5'd16 || ir !== 1'b0) begin errors++; $display("FAIL fill_full: got level %0d in_ready %0b expected 16 0", lv, ir); end
    checks++;
    if (a_hw !== 5'(a_hw_m)) begin errors++; $display("FAIL fill_high_water: got %0d expected %0d", a_hw, a_hw_m); end
    drive_a(1'b0, 8'h00, 1'b0, ov, od, lv, ir, pp, ex);
    checks++;
    if (lv !== 5'd16 || od !== 8'h00) begin errors++; $display("FAIL fill_17th_rejected: got level %0d head %02h expected 16 00", lv, od); end
  endtask

  task automatic test_full_simul;
    logic ov, ir, pp; logic [7:0] od, ex; logic [4:0] lv;
    drive_a(1'b1, 8'hAA, 1'b1, ov, od, lv, ir, pp, ex);
    checks++;
    if (!pp || od !== 8'h00 || od !== ex) begin errors++; $display("FAIL full_simul_pop: got %02h expected %02h", od, ex); end
    drive_a(1'b0, 8'h00, 1'b0, ov, od, lv, ir, pp, ex);
    checks++;
    if (lv !== 5'd15 || ir !== 1'b1) begin errors++; $display("FAIL full_simul_after: got level %0d in_ready %0b expected 15 1", lv, ir); end
    checks++;
    if (a_hw !== 5'd16) begin errors++; $display("FAIL full_simul_high_water: got %0d expected 16", a_hw); end
    for (int i = 1; i < 16; i++) begin
      drive_a(1'b0, 8'h00, 1'b1, ov, od, lv, ir, pp, ex);
      checks++;
      if (!pp || od !== 8'(i) || od !== ex) begin errors++; $display("FAIL drain_order: got %02h expected %02h", od, 8'(i)); end
    end
    drive_a(1'b0, 8'h00, 1'b0, ov, od, lv, ir, pp, ex);
    checks++;
    if (lv !== 5'd0 || ov !== 1'b0) begin errors++; $display("FAIL drain_empty: got level %0d valid %0b expected 0 0", lv, ov); end
  endtask

  task automatic test_drop;
    logic [7:0] od;
    for (int i = 0; i < 4; i++) drive_b(1'b1, 8'hB0 + 8'(i), 1'b0, od);
    for (int i = 0; i < 20; i++) drive_b(1'b1, 8'hEE, 1'b0, od);
    drive_b(1'b0, 8'h00, 1'b0, od);
    checks++;
    if (b_drop !== 5'd20) begin errors++; $display("FAIL drop_count: got %0d expected 20", b_drop); end
    checks++;
    if (b_level !== 3'd4 || b_if.in_ready !== 1'b1) begin errors++; $display("FAIL drop_level_ready: got level %0d in_ready %0b expected 4 1", b_level, b_if.in_ready); end
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b0, 8'h00, 1'b1, od);
      checks++;
      if (od !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL drop_contents: got %02h expected %02h", od, 8'hB0 + 8'(i)); end
    end
    for (int i = 0; i < 4; i++) drive_b(1'b1, 8'hC0 + 8'(i), 1'b0, od);
    for (int i = 0; i < 15; i++) drive_b(1'b1, 8'hEE, 1'b0, od);
    checks++;
    if (b_drop !== 5'h1F) begin errors++; $display("FAIL drop_saturate: got %0d expected 31", b_drop); end
    for (int i = 0; i < 3; i++) drive_b(1'b1, 8'hEE, 1'b0, od);
    drive_b(1'b0, 8'h00, 1'b0, od);
    checks++;
    if (b_drop !== 5'h1F || b_if.out_data !== 8'hC0) begin errors++; $display("FAIL drop_hold: got cnt %0d head %02h expected 31 c0", b_drop, b_if.out_data); end
  endtask

  task automatic test_random_wrap;
    logic ov, ir, pp; logic [7:0] od, ex; logic [4:0] lv;
    logic v, r; logic [7:0] d;
    int accepted = 0;
    int budget = 0;
    while (accepted < 100 && budget < 2000) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (v && a_cnt < 16) accepted++;
      drive_a(v, d, r, ov, od, lv, ir, pp, ex);
      if (pp) begin
        checks++;
        if (ov !== 1'b1 || od !== ex) begin errors++; $display("FAIL random_data: got valid %0b data %02h expected 1 %02h", ov, od, ex); end
      end
      budget++;
    end
    checks++;
    if (accepted < 100) begin errors++; $display("FAIL random_budget: got %0d bytes expected 100", accepted); end
    budget = 0;
    while (a_cnt > 0 && budget < 64) begin
      drive_a(1'b0, 8'h00, 1'b1, ov, od, lv, ir, pp, ex);
      checks++;
      if (ov !== 1'b1 || od !== ex) begin errors++; $display("FAIL random_drain: got %02h expected %02h", od, ex); end
      budget++;
    end
    checks++;
    if (a_level !== 5'd0 || a_hw !== 5'(a_hw_m)) begin errors++; $display("FAIL random_final: got level %0d hw %0d expected 0 %0d", a_level, a_hw, a_hw_m); end
  endtask

  task automatic test_reset_mid;
    logic ov, ir, pp; logic [7:0] od, ex; logic [4:0] lv;
    for (int i = 0; i < 5; i++) drive_a(1'b1, 8'h60 + 8'(i), 1'b0, ov, od, lv, ir, pp, ex);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (a_if.out_valid !== 1'b0 || a_level !== 5'd0) begin errors++; $display("FAIL async_reset: got valid %0b level %0d expected 0 0", a_if.out_valid, a_level); end
    checks++;
    if (a_if.in_ready !== 1'b0 || a_hw !== 5'd0) begin errors++; $display("FAIL async_reset_stats: got in_ready %0b hw %0d expected 0 0", a_if.in_ready, a_hw); end
    a_q.delete();
    a_cnt = 0;
    a_hw_m = 0;
    a_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive_a(1'b1, 8'h77, 1'b0, ov, od, lv, ir, pp, ex);
    drive_a(1'b0, 8'h00, 1'b1, ov, od, lv, ir, pp, ex);
    checks++;
    if (!pp || od !== ex || lv !== 5'd1) begin errors++; $display("FAIL post_reset_push: got %02h level %0d expected %02h 1", od, lv, ex); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_drop();
    test_random_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
